// File: rtl/mdl_fsm_pkg.sv
// Shared constants for the job dispatcher.
// State encoding, error codes and the no-op mode value.
package mdl_fsm_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_MODE  = 2'b01;
   localparam logic [1:0] ERR_TMO   = 2'b10;
   localparam logic [1:0] ERR_ABORT = 2'b11;

   localparam int MODE_NOP = 0;

endpackage

// File: rtl/mdl_tmo_cnt.sv
// Saturating run-cycle counter with watchdog compare.
// Ports: clk/rst, clr, en, limit in; elapsed (cnt+1, saturating), tmo out.
module mdl_tmo_cnt
   import mdl_fsm_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic [W-1:0] elapsed,
   output logic         tmo
);

   logic [W-1:0] cnt;
   logic         sat;

   assign sat = &cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !sat) begin
         cnt <= cnt + W'(1);
      end
   end

   assign elapsed = sat ? cnt : cnt + W'(1);

   // Equality only: a limit lowered below elapsed never fires.
   assign tmo = (limit != '0) && (elapsed == limit);

endmodule

// File: rtl/mdl_fsm_dispatch.sv
// Job dispatcher: one command at a time, start pulse, wait for done.
// Ports: cmd valid/ready/mode, engine start/done, watchdog, abort, status.
module mdl_fsm_dispatch
   import mdl_fsm_pkg::*;
#(
   parameter int NUM_ENG = 2,
   parameter int MODE_W  = 3,
   parameter int TMO_W   = 16
) (
   input  logic               iSYS_CLK,
   input  logic               iSYS_RST,
   input  logic               iCMD_VALID,
   input  logic [MODE_W-1:0]  iCMD_MODE,
   output logic               oCMD_READY,
   input  logic [NUM_ENG-1:0] iENG_DONE,
   input  logic [TMO_W-1:0]   iTMO_LIMIT,
   input  logic               iABORT,
   output logic [NUM_ENG-1:0] oENG_START,
   output logic               oBUSY,
   output logic [MODE_W-1:0]  oACTIVE_ID,
   output logic               oDONE,
   output logic               oERR,
   output logic [1:0]         oERR_CODE,
   output logic [TMO_W-1:0]   oCYCLES
);

   logic [0:0]         state;
   logic [NUM_ENG-1:0] start_q;
   logic [NUM_ENG-1:0] sel_q;
   logic [MODE_W-1:0]  id_q;
   logic               done_q;
   logic               err_q;
   logic [1:0]         code_q;
   logic [TMO_W-1:0]   cyc_q;

   logic               hs;
   logic               mode_ok;
   logic               mode_bad;
   logic               accept;
   logic               done_hit;
   logic               run;
   logic [TMO_W-1:0]   elapsed;
   logic               tmo;
   logic [NUM_ENG-1:0] mode_oh;

   function automatic logic [NUM_ENG-1:0] dec_oh(
      input logic [MODE_W-1:0] m
   );
      logic [NUM_ENG-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_ENG; i++) begin
         oh[i] = (m == MODE_W'(i + 1));
      end
      return oh;
   endfunction

   assign run        = (state == ST_RUN);
   assign oCMD_READY = (state == ST_IDLE);
   assign hs         = iCMD_VALID && oCMD_READY;
   assign mode_bad   = (iCMD_MODE > MODE_W'(NUM_ENG));
   assign mode_ok    = (iCMD_MODE != MODE_W'(MODE_NOP)) && !mode_bad;
   assign accept     = hs && mode_ok;
   assign mode_oh    = dec_oh(iCMD_MODE);

   // Remembered one-hot select masks out done bits of other engines.
   assign done_hit = |(iENG_DONE & sel_q);

   mdl_tmo_cnt #(
      .W(TMO_W)
   ) u_cnt (
      .clk     (iSYS_CLK),
      .rst     (iSYS_RST),
      .clr     (accept),
      .en      (run),
      .limit   (iTMO_LIMIT),
      .elapsed (elapsed),
      .tmo     (tmo)
   );

   always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
      if (iSYS_RST) begin
         state   <= ST_IDLE;
         start_q <= '0;
         sel_q   <= '0;
         id_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         cyc_q   <= '0;
      end else begin
         start_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (state == ST_IDLE) begin
            if (accept) begin
               state   <= ST_RUN;
               start_q <= mode_oh;
               sel_q   <= mode_oh;
               id_q    <= iCMD_MODE;
            end else if (hs && mode_bad) begin
               err_q  <= 1'b1;
               code_q <= ERR_MODE;
            end
         end else begin
            if (done_hit) begin
               state  <= ST_IDLE;
               done_q <= 1'b1;
               cyc_q  <= elapsed;
            end else if (tmo) begin
               state  <= ST_IDLE;
               err_q  <= 1'b1;
               code_q <= ERR_TMO;
               cyc_q  <= elapsed;
            end else if (iABORT) begin
               state  <= ST_IDLE;
               err_q  <= 1'b1;
               code_q <= ERR_ABORT;
               cyc_q  <= elapsed;
            end
         end
      end
   end

   assign oENG_START = start_q;
   assign oBUSY      = run;
   assign oACTIVE_ID = id_q;
   assign oDONE      = done_q;
   assign oERR       = err_q;
   assign oERR_CODE  = code_q;
   assign oCYCLES    = cyc_q;

endmodule

// File: tb/tb_mdl_fsm_dispatch.sv
// Bench for mdl_fsm_dispatch: directed jobs plus random jobs.
// Expected outcomes come from a per-job scan of the dispatch rules.
module tb_mdl_fsm_dispatch;

   localparam int NE = 2;
   localparam int MW = 3;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0;
   logic [MW-1:0] mode = '0;
   logic [NE-1:0] eng_done = '0;
   logic [TW-1:0] lim = '0;
   logic          abort = 1'b0;

   logic          ready;
   logic [NE-1:0] start;
   logic          busy;
   logic [MW-1:0] act_id;
   logic          done;
   logic          err;
   logic [1:0]    code;
   logic [TW-1:0] cycles;

   int total = 0;
   int bad = 0;

   logic [1:0]    exp_code = 2'b00;
   logic [MW-1:0] exp_id = '0;
   logic [TW-1:0] exp_cyc = '0;

   mdl_fsm_dispatch #(
      .NUM_ENG(NE),
      .MODE_W (MW),
      .TMO_W  (TW)
   ) dut (
      .iSYS_CLK   (clk),
      .iSYS_RST   (rst),
      .iCMD_VALID (valid),
      .iCMD_MODE  (mode),
      .oCMD_READY (ready),
      .iENG_DONE  (eng_done),
      .iTMO_LIMIT (lim),
      .iABORT     (abort),
      .oENG_START (start),
      .oBUSY      (busy),
      .oACTIVE_ID (act_id),
      .oDONE      (done),
      .oERR       (err),
      .oERR_CODE  (code),
      .oCYCLES    (cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag);
      chk({tag, "_code"}, 32'(code), 32'(exp_code));
      chk({tag, "_id"}, 32'(act_id), 32'(exp_id));
      chk({tag, "_cyc"}, 32'(cycles), 32'(exp_cyc));
   endtask

   function automatic int lim_at(input int k, input int l0,
                                 input int ck, input int l1);
      return (ck >= 0 && k >= ck) ? l1 : l0;
   endfunction

   // kind: 1 done, 2 timeout, 3 abort
   task automatic run_job(input int m, input int done_at,
                          input int wrong_at, input int abort_at,
                          input int l0, input int ck, input int l1,
                          input bit noise);
      int end_k;
      int kind;
      int l;
      logic [NE-1:0] oh;
      logic [NE-1:0] nz;
      valid = 1'b1;
      mode = MW'(m);
      lim = TW'(l0);
      abort = 1'b0;
      eng_done = '0;
      tick();
      valid = 1'b0;
      if (m == 0 || m > NE) begin
         if (m > NE) exp_code = 2'b01;
         chk("nop_pulse", {ready, busy, start, done, err},
             {1'b1, 1'b0, NE'(0), 1'b0, (m > NE)});
         chk_status("nop");
         tick();
         chk("nop_after", {busy, start, done, err}, '0);
         return;
      end
      oh = NE'(1) << (m - 1);
      exp_id = MW'(m);
      chk("start", 32'(start), 32'(oh));
      chk("t1_flags", {ready, busy, done, err}, 4'b0100);
      chk("t1_id", 32'(act_id), 32'(exp_id));
      end_k = -1;
      kind = 0;
      for (int k = 0; k < 300; k++) begin
         l = lim_at(k, l0, ck, l1);
         if (k == done_at) kind = 1;
         else if (l != 0 && k + 1 == l) kind = 2;
         else if (k == abort_at) kind = 3;
         if (kind != 0) begin
            end_k = k;
            break;
         end
      end
      for (int k = 0; k <= end_k; k++) begin
         lim = TW'(lim_at(k, l0, ck, l1));
         abort = (k == abort_at);
         nz = noise ? NE'($urandom) : '0;
         eng_done = ((k == done_at) ? oh : '0)
                  | ((k == wrong_at) ? ~oh : '0)
                  | (nz & ~oh);
         if (noise) begin
            valid = 1'($urandom_range(0, 1));
            mode = MW'($urandom_range(0, 7));
         end
         tick();
         if (k < end_k) begin
            chk("run", {busy, start, done, err},
                {1'b1, NE'(0), 2'b00});
         end
      end
      valid = 1'b0;
      abort = 1'b0;
      eng_done = '0;
      lim = '0;
      exp_cyc = TW'(end_k + 1);
      if (kind == 2) exp_code = 2'b10;
      if (kind == 3) exp_code = 2'b11;
      chk("end_flags", {ready, busy, start, done, err},
          {1'b1, 1'b0, NE'(0), (kind == 1), (kind != 1)});
      chk_status("end");
      tick();
      chk("end_after", {ready, busy, start, done, err},
          {1'b1, 1'b0, NE'(0), 2'b00});
   endtask

   initial begin
      #3;
      chk("rst_flags", {ready, busy, start, done, err},
          {1'b1, 1'b0, NE'(0), 2'b00});
      chk_status("rst");
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rst_rel", {ready, busy, start}, {2'b10, NE'(0)});

      run_job(2, 4, -1, -1, 0, -1, 0, 1'b0);
      run_job(1, 3, 2, -1, 0, -1, 0, 1'b0);
      run_job(1, -1, -1, -1, 8, -1, 0, 1'b0);
      run_job(1, 7, -1, -1, 8, -1, 0, 1'b0);
      run_job(5, -1, -1, -1, 0, -1, 0, 1'b0);
      run_job(1, -1, -1, 2, 0, -1, 0, 1'b0);
      run_job(0, -1, -1, -1, 0, -1, 0, 1'b0);
      run_job(2, 9, -1, -1, 20, 6, 3, 1'b0);
      run_job(1, 0, -1, -1, 0, -1, 0, 1'b0);
      run_job(2, -1, -1, 3, 4, -1, 0, 1'b0);
      run_job(7, -1, -1, -1, 0, -1, 0, 1'b0);

      abort = 1'b1;
      tick();
      tick();
      abort = 1'b0;
      chk("idle_abort", {ready, busy, start, done, err},
          {1'b1, 1'b0, NE'(0), 2'b00});
      chk_status("idle_abort");

      for (int j = 0; j < 40; j++) begin
         int m;
         int da;
         int aa;
         int l0;
         m = int'($urandom_range(0, 7));
         da = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 25));
         aa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 25)) : -1;
         l0 = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
         if (da < 0 && aa < 0 && l0 == 0) da = 10;
         run_job(m, da, -1, aa, l0, -1, 0, 1'b1);
      end

      valid = 1'b1;
      mode = 3'd1;
      lim = '0;
      eng_done = '0;
      tick();
      chk("b2b_start1", 32'(start), 32'h1);
      exp_id = 3'd1;
      eng_done = 2'b01;
      tick();
      exp_cyc = 16'd1;
      chk("b2b_done", {ready, busy, done, err}, 4'b1010);
      chk_status("b2b");
      eng_done = '0;
      tick();
      chk("b2b_start2", {busy, start, done}, {1'b1, NE'(1), 1'b0});
      valid = 1'b0;
      tick();
      chk("b2b_run", {busy, start}, {1'b1, NE'(0)});

      #2;
      rst = 1'b1;
      #1;
      exp_code = 2'b00;
      exp_id = '0;
      exp_cyc = '0;
      chk("mid_rst", {ready, busy, start, done, err},
          {1'b1, 1'b0, NE'(0), 2'b00});
      chk_status("mid_rst");
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst", {ready, busy, start, done, err},
          {1'b1, 1'b0, NE'(0), 2'b00});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdl_fsm_dispatch.md
Name: mdl_fsm_dispatch

Overview:
- Parametrised job dispatcher for the accelerator, successor to the two-engine (butterfly/Keccak) start FSM.
- Accepts one command at a time over a valid/ready handshake.
- Fires a single-cycle start pulse to one of NUM_ENG engines, then waits for that engine's done.
- Reports completion with a cycle count; reports invalid-mode, watchdog-timeout and abort errors.

Parameters:
- NUM_ENG, 2: number of engines. Must be 1..(2^MODE_W - 1).
- MODE_W, 3: command mode width. Mode 0 = no-op; mode k (1..NUM_ENG) = engine k-1.
- TMO_W, 16: width of the cycle counter and the timeout limit.

Ports:
- iSYS_CLK  in  1  system clock; all logic on its rising edge.
- iSYS_RST  in  1  reset, asynchronous, active-high.
- iCMD_VALID  in  1  command valid.
- iCMD_MODE  in  MODE_W  command mode.
- oCMD_READY  out  1  dispatcher can accept a command.
- iENG_DONE  in  NUM_ENG  per-engine done, level or pulse.
- iTMO_LIMIT  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog.
- iABORT  in  1  abort the running job.
- oENG_START  out  NUM_ENG  one-hot start pulse, registered.
- oBUSY  out  1  job in progress.
- oACTIVE_ID  out  MODE_W  mode of the last accepted engine command.
- oDONE  out  1  one-cycle completion pulse.
- oERR  out  1  one-cycle error pulse.
- oERR_CODE  out  2  01 invalid mode, 10 timeout, 11 abort; holds until the next error.
- oCYCLES  out  TMO_W  RUN-cycle count of the last finished or errored job.

Behaviour:
- States: IDLE, RUN.
- Reset: state IDLE; oCMD_READY=1; all other outputs 0; internal counter 0.
- Reset asserted mid-RUN returns to IDLE immediately. No oDONE or oERR is issued.
- oCMD_READY = (state==IDLE), combinational from state. oBUSY = (state==RUN), registered.
- A handshake occurs in cycle T when iCMD_VALID and oCMD_READY are both high.
- IDLE, handshake with mode 0: accepted, no effect, stay IDLE.
- IDLE, handshake with mode > NUM_ENG: accepted, stay IDLE. At T+1: oERR=1, oERR_CODE=01.
- IDLE, handshake with mode 1..NUM_ENG: at T+1 state=RUN, oBUSY=1, oACTIVE_ID=mode, and oENG_START[mode-1]=1 for exactly cycle T+1.
- oENG_START is never asserted outside that single cycle and is always one-hot or zero.
- iCMD_VALID while not ready is ignored. The requester must hold the command until ready.
- RUN counter: cnt is 0 at T+1 and increments each RUN cycle, saturating at all-ones. "Elapsed" = cnt+1, saturating.
- RUN completion: only iENG_DONE[active] is honoured; other done bits are ignored. The done may arrive as early as T+1. If it is sampled in cycle D: at D+1 state=IDLE, oDONE=1, oCYCLES=elapsed at D, oBUSY=0, oCMD_READY=1.
- A new command may handshake in D+1, so back-to-back jobs have a 2-cycle gap between start pulses minimum.
- RUN timeout: iTMO_LIMIT≠0, elapsed==iTMO_LIMIT and no done. Next cycle: IDLE, oERR=1, oERR_CODE=10, oCYCLES=elapsed.
- iTMO_LIMIT is sampled live each cycle. Lowering it below elapsed mid-job does not fire a timeout; the comparison is equality only.
- RUN abort: iABORT=1. Next cycle: IDLE, oERR=1, oERR_CODE=11, oCYCLES=elapsed.
- Priority within one cycle: done > timeout > abort.
- iABORT in IDLE is ignored.
- oDONE and oERR are never high in the same cycle.
- oACTIVE_ID and oCYCLES hold their values until they are next updated.

Decomposition:
- Package mdl_fsm_pkg: state encoding (IDLE=0, RUN=1), error code constants (ERR_NONE=00, ERR_MODE=01, ERR_TMO=10, ERR_ABORT=11), and the mode-0 no-op constant.
- Sub-module mdl_tmo_cnt: saturating TMO_W counter with clear/enable and an equality compare against the limit, producing a timeout flag.
- The top level holds the FSM, the start-pulse register, and the status registers.

Test Plan:
- Reset then idle: with iSYS_RST=1 asserted asynchronously mid-cycle, oCMD_READY=1 and all other outputs are 0 at once. After release, oCMD_READY stays 1.
- Dispatch (NUM_ENG=2): mode=2 at T. oENG_START=2'b10 at T+1 only. iENG_DONE[1] at T+5 → oDONE at T+6, oCYCLES=5, oBUSY=0.
- Wrong-engine done: mode=1 at T, iENG_DONE=2'b10 at T+3 → ignored, oBUSY stays 1. iENG_DONE=2'b01 at T+4 → oDONE at T+5, oCYCLES=4.
- Timeout: iTMO_LIMIT=8, mode=1, no done → oERR=1 with code 10 exactly 8 RUN cycles after T+1, oCYCLES=8. Repeat with done and timeout in the same cycle → oDONE only.
- Invalid mode / abort: mode=5 → oERR, code 01, no start pulse. Mode=1 then iABORT at T+3 → oERR, code 11, oCYCLES=3. iABORT in IDLE → no response.
- Back-to-back: hold iCMD_VALID with mode=1. The second handshake occurs in the same cycle oDONE pulses. Mid-RUN async reset clears oBUSY with no oDONE.
